// File: rtl/ternary_dot_engine_if.sv
// ============================================================================
// Module  : ternary_dot_engine_if
// Purpose : Job, operand-stream and result handshake bundle for ternary_dot_engine.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface ternary_dot_engine_if #(
    parameter int LANES = 8,
    parameter int ACT_W = 8,
    parameter int ACC_W = 24,
    parameter int LEN_W = 10
);
    localparam int CNT_W = LEN_W + $clog2(LANES) + 1;

    logic                     start;
    logic [LEN_W-1:0]         len;
    logic                     busy;
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*ACT_W-1:0]   in_act;
    logic [2*LANES-1:0]       in_wt;
    logic                     result_valid;
    logic                     result_ready;
    logic [ACC_W-1:0]         result;
    logic [CNT_W-1:0]         nnz_count;
    logic                     sat_flag;
    logic                     err_flag;

    modport master (
        output start, len, in_valid, in_act, in_wt, result_ready,
        input  busy, in_ready, result_valid, result, nnz_count, sat_flag, err_flag
    );

    modport slave (
        input  start, len, in_valid, in_act, in_wt, result_ready,
        output busy, in_ready, result_valid, result, nnz_count, sat_flag, err_flag
    );
endinterface

`default_nettype wire

// File: rtl/ternary_dot_engine.sv
// ============================================================================
// Module  : ternary_dot_engine
// Purpose : Streaming saturating dot product of signed activations with ternary weights.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ternary_dot_engine #(
    parameter int LANES = 8,
    parameter int ACT_W = 8,
    parameter int ACC_W = 24,
    parameter int LEN_W = 10
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    ternary_dot_engine_if.slave   bus
);
    localparam int CNT_W = LEN_W + $clog2(LANES) + 1;
    localparam int SUM_W = ACT_W + 1 + $clog2(LANES);
    localparam int EXT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;

    localparam logic signed [EXT_W-1:0] c_acc_max = {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] c_acc_min = ~c_acc_max;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [LEN_W-1:0]          r_remain;
    logic                      r_s1_valid;
    logic signed [SUM_W-1:0]   r_sum;
    logic signed [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]          r_nnz;
    logic                      r_sat;
    logic                      r_err;

    logic                      w_in_ready;
    logic                      w_beat;
    logic                      w_start_acc;
    logic                      w_busy;
    logic                      w_res_valid;
    logic signed [SUM_W-1:0]   w_act_x [LANES];
    logic signed [SUM_W-1:0]   w_lane_sum;
    logic [CNT_W-1:0]          w_nnz_beat;
    logic                      w_err_beat;
    logic signed [EXT_W-1:0]   w_acc_ext;

    assign w_in_ready  = (r_state == S_RUN) && (r_remain != '0);
    assign w_beat      = bus.in_valid && w_in_ready;
    assign w_start_acc = (r_state == S_IDLE) && bus.start;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_act_x[g] = SUM_W'($signed(bus.in_act[g*ACT_W +: ACT_W]));
    end

    // Full-precision lane reduction; an illegal 11 trit contributes nothing.
    always_comb begin
        w_lane_sum = '0;
        w_nnz_beat = '0;
        w_err_beat = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            case (bus.in_wt[2*i +: 2])
                2'b10: begin
                    w_lane_sum = w_lane_sum + w_act_x[i];
                    w_nnz_beat = w_nnz_beat + CNT_W'(1);
                end
                2'b00: begin
                    w_lane_sum = w_lane_sum - w_act_x[i];
                    w_nnz_beat = w_nnz_beat + CNT_W'(1);
                end
                2'b11:   w_err_beat = 1'b1;
                default: ;
            endcase
        end
    end

    assign w_acc_ext = EXT_W'(r_acc) + EXT_W'(r_sum);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_busy      = 1'b1;
        w_res_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_next = (bus.len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_beat && (r_remain == LEN_W'(1))) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!r_s1_valid) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_res_valid = 1'b1;
                if (bus.result_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Result fields persist after the handshake and clear only on the next accepted start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_remain   <= '0;
            r_s1_valid <= 1'b0;
            r_sum      <= '0;
            r_acc      <= '0;
            r_nnz      <= '0;
            r_sat      <= 1'b0;
            r_err      <= 1'b0;
        end else if (w_start_acc) begin
            r_remain   <= bus.len;
            r_s1_valid <= 1'b0;
            r_sum      <= '0;
            r_acc      <= '0;
            r_nnz      <= '0;
            r_sat      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_s1_valid <= w_beat;
            if (w_beat) begin
                r_sum    <= w_lane_sum;
                r_nnz    <= r_nnz + w_nnz_beat;
                r_err    <= r_err | w_err_beat;
                r_remain <= r_remain - LEN_W'(1);
            end
            if (r_s1_valid) begin
                if (w_acc_ext > c_acc_max) begin
                    r_acc <= c_acc_max[ACC_W-1:0];
                    r_sat <= 1'b1;
                end else if (w_acc_ext < c_acc_min) begin
                    r_acc <= c_acc_min[ACC_W-1:0];
                    r_sat <= 1'b1;
                end else begin
                    r_acc <= w_acc_ext[ACC_W-1:0];
                end
            end
        end
    end

    assign bus.busy         = w_busy;
    assign bus.in_ready     = w_in_ready;
    assign bus.result_valid = w_res_valid;
    assign bus.result       = r_acc;
    assign bus.nnz_count    = r_nnz;
    assign bus.sat_flag     = r_sat;
    assign bus.err_flag     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ternary_dot_engine.sv
// ============================================================================
// Module  : tb_ternary_dot_engine
// Purpose : Directed self-checking bench for ternary_dot_engine (ACC_W=24 and ACC_W=10).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ternary_dot_engine;
    logic clk;
    logic reset_n;
    int   n_total;
    int   n_bad;

    ternary_dot_engine_if #(.LANES(8), .ACT_W(8), .ACC_W(24), .LEN_W(10)) bus ();
    ternary_dot_engine_if #(.LANES(8), .ACT_W(8), .ACC_W(10), .LEN_W(10)) bus10 ();

    ternary_dot_engine #(.LANES(8), .ACT_W(8), .ACC_W(24), .LEN_W(10)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    ternary_dot_engine #(.LANES(8), .ACT_W(8), .ACC_W(10), .LEN_W(10)) u_dut10 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // All tasks are entered and left just after a falling edge.
    task automatic start_job(input logic [9:0] l);
        bus.start = 1'b1;
        bus.len   = l;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] act, input logic [15:0] wt);
        int g;
        g = 0;
        bus.in_act   = act;
        bus.in_wt    = wt;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20) chk("beat_timeout", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result();
        int g;
        g = 0;
        while (!bus.result_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("result_wait", 32'(bus.result_valid), 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [23:0] r, input logic [13:0] nnz,
                                input logic sat, input logic err);
        chk({tag, "_result"}, 32'(bus.result), 32'(r));
        chk({tag, "_nnz"},    32'(bus.nnz_count), 32'(nnz));
        chk({tag, "_sat"},    32'(bus.sat_flag), 32'(sat));
        chk({tag, "_err"},    32'(bus.err_flag), 32'(err));
    endtask

    task automatic handshake();
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        chk("hs_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int cnt;
        int cyc;
        n_total = 0;
        n_bad   = 0;
        reset_n = 1'b0;
        bus.start = 1'b0;   bus.len = '0;   bus.in_valid = 1'b0;
        bus.in_act = '0;    bus.in_wt = '0; bus.result_ready = 1'b0;
        bus10.start = 1'b0; bus10.len = '0; bus10.in_valid = 1'b0;
        bus10.in_act = '0;  bus10.in_wt = '0; bus10.result_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // reset state
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_rvalid", 32'(bus.result_valid), 32'd0);
        check_result("rst", 24'd0, 14'd0, 1'b0, 1'b0);

        // 1: all ones, latency E+2
        start_job(10'd1);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        send_beat({8{8'h01}}, 16'hAAAA);
        chk("t1_lat_e1", 32'(bus.result_valid), 32'd0);
        @(negedge clk);
        chk("t1_lat_e2", 32'(bus.result_valid), 32'd0);
        @(negedge clk);
        chk("t1_lat_e3", 32'(bus.result_valid), 32'd1);
        check_result("t1", 24'd8, 14'd8, 1'b0, 1'b0);
        handshake();

        // 2: cancelling weights, then -(-128) x 8
        start_job(10'd1);
        send_beat({8{8'h05}}, 16'h2222);
        wait_result();
        check_result("t2a", 24'd0, 14'd8, 1'b0, 1'b0);
        handshake();
        start_job(10'd1);
        send_beat({8{8'h80}}, 16'h0000);
        wait_result();
        check_result("t2b", 24'd1024, 14'd8, 1'b0, 1'b0);
        handshake();

        // 3: saturation on the narrow instance, back-to-back beats
        bus10.start = 1'b1;
        bus10.len   = 10'd4;
        @(negedge clk);
        bus10.start    = 1'b0;
        bus10.in_act   = {8{8'h7F}};
        bus10.in_wt    = 16'hAAAA;
        bus10.in_valid = 1'b1;
        cnt = 0;
        cyc = 0;
        while (cnt < 4 && cyc < 20) begin
            if (bus10.in_ready) cnt++;
            @(negedge clk);
            cyc++;
        end
        bus10.in_valid = 1'b0;
        chk("t3_throughput", 32'(cyc), 32'd4);
        cyc = 0;
        while (!bus10.result_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("t3_rvalid", 32'(bus10.result_valid), 32'd1);
        chk("t3_result", 32'(bus10.result), 32'd511);
        chk("t3_sat", 32'(bus10.sat_flag), 32'd1);
        chk("t3_nnz", 32'(bus10.nnz_count), 32'd32);
        bus10.result_ready = 1'b1;
        @(negedge clk);
        bus10.result_ready = 1'b0;
        chk("t3_busy", 32'(bus10.busy), 32'd0);

        // 4: illegal trit on lane 0
        start_job(10'd1);
        send_beat({8{8'h03}}, 16'hAAAB);
        wait_result();
        check_result("t4", 24'd21, 14'd7, 1'b0, 1'b1);
        handshake();

        // 5: gapped stream, back-pressure, ignored starts
        start_job(10'd3);
        send_beat({8{8'h02}}, 16'hAAAA);
        repeat (2) @(negedge clk);
        send_beat({8{8'h02}}, 16'hAAAA);
        repeat (3) @(negedge clk);
        send_beat({8{8'h02}}, 16'hAAAA);
        wait_result();
        check_result("t5", 24'd48, 14'd24, 1'b0, 1'b0);
        bus.start = 1'b1;
        bus.len   = 10'd5;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t5_hold_result", 32'(bus.result), 32'd48);
            chk("t5_hold_busy", 32'(bus.busy), 32'd1);
            chk("t5_hold_rvalid", 32'(bus.result_valid), 32'd1);
        end
        bus.len = 10'd0;
        handshake();
        bus.start = 1'b0;
        chk("t5_after_hs_result", 32'(bus.result), 32'd48);
        chk("t5_after_hs_rvalid", 32'(bus.result_valid), 32'd0);
        start_job(10'd0);
        chk("t5_len0_rvalid", 32'(bus.result_valid), 32'd1);
        check_result("t5_len0", 24'd0, 14'd0, 1'b0, 1'b0);
        handshake();

        // 6: reset during beat 2 of a 4-beat job
        start_job(10'd4);
        send_beat({8{8'h01}}, 16'hAAAA);
        bus.in_act   = {8{8'h01}};
        bus.in_wt    = 16'hAAAA;
        bus.in_valid = 1'b1;
        reset_n      = 1'b0;
        @(negedge clk);
        reset_n      = 1'b1;
        bus.in_valid = 1'b0;
        chk("t6_busy", 32'(bus.busy), 32'd0);
        chk("t6_in_ready", 32'(bus.in_ready), 32'd0);
        chk("t6_rvalid", 32'(bus.result_valid), 32'd0);
        check_result("t6", 24'd0, 14'd0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("t6_no_result", 32'(bus.result_valid), 32'd0);
        start_job(10'd1);
        send_beat({8{8'h01}}, 16'hAAAA);
        wait_result();
        check_result("t6_rerun", 24'd8, 14'd8, 1'b0, 1'b0);
        handshake();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
